// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester handshakes and the single data-memory port.
// The arbiter connects through 'slave'; requesters and memory drive the 'master' side.
interface data_mem_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_ack;
  logic        p0_err;
  logic [31:0] p0_rdata;

  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_ack;
  logic        p1_err;
  logic [31:0] p1_rdata;

  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  logic        busy;
  logic        grant;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_read_data,
    output p0_ack, p0_err, p0_rdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_address, mem_write_data, mem_read, mem_write,
    output busy, grant
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_read_data,
    input  p0_ack, p0_err, p0_rdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_address, mem_write_data, mem_read, mem_write,
    input  busy, grant
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin two-port sequencer in front of the word-wide data memory.
// Every output is a flop; accesses go IDLE -> (ISSUE -> (WAIT) ->) DONE -> IDLE.
module data_mem_arbiter #(
  parameter int MEM_BYTES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic             we_q, we_d;
  logic             illegal_q, illegal_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       err_q, err_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic [31:0]      mem_address_q, mem_address_d;
  logic [31:0]      mem_write_data_q, mem_write_data_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             busy_q, busy_d;
  logic             grant_q, grant_d;

  logic [1:0]       req_w;
  logic [1:0]       we_w;
  logic [1:0][31:0] addr_w;
  logic [1:0][31:0] wdata_w;

  logic [1:0]       eff_req;
  logic             win;
  logic             win_illegal;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      if (gi == 0) begin : g_p0
        assign req_w[gi]   = bus.p0_req;
        assign we_w[gi]    = bus.p0_we;
        assign addr_w[gi]  = bus.p0_addr;
        assign wdata_w[gi] = bus.p0_wdata;
        assign bus.p0_ack   = ack_q[gi];
        assign bus.p0_err   = err_q[gi];
        assign bus.p0_rdata = rdata_q[gi];
      end else begin : g_p1
        assign req_w[gi]   = bus.p1_req;
        assign we_w[gi]    = bus.p1_we;
        assign addr_w[gi]  = bus.p1_addr;
        assign wdata_w[gi] = bus.p1_wdata;
        assign bus.p1_ack   = ack_q[gi];
        assign bus.p1_err   = err_q[gi];
        assign bus.p1_rdata = rdata_q[gi];
      end
    end
  endgenerate

  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_write_data_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.busy           = busy_q;
  assign bus.grant          = grant_q;

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    id_d             = id_q;
    we_d             = we_q;
    illegal_d        = illegal_q;
    ack_d            = '0;
    err_d            = '0;
    rdata_d          = rdata_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_read_d       = 1'b0;
    mem_write_d      = 1'b0;
    grant_d          = grant_q;
    win              = 1'b0;
    win_illegal      = 1'b0;

    // A port whose ack is showing this cycle is still lowering req; ignore it.
    eff_req = req_w & ~ack_q;

    case (state_q)
      IDLE: begin
        if (|eff_req) begin
          win          = (&eff_req) ? ~last_grant_q : eff_req[1];
          win_illegal  = (addr_w[win][1:0] != 2'b00) || (addr_w[win] > MAX_ADDR);
          id_d         = win;
          grant_d      = win;
          last_grant_d = win;
          we_d         = we_w[win];
          illegal_d    = win_illegal;
          if (win_illegal) begin
            state_d = DONE;
          end else begin
            state_d          = ISSUE;
            mem_address_d    = addr_w[win];
            mem_write_data_d = wdata_w[win];
            mem_read_d       = ~we_w[win];
            mem_write_d      = we_w[win];
          end
        end
      end
      ISSUE: begin
        state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        rdata_d[id_q] = bus.mem_read_data;
        state_d       = DONE;
      end
      DONE: begin
        ack_d[id_q] = 1'b1;
        err_d[id_q] = illegal_q;
        if (illegal_q) begin
          rdata_d[id_q] = '0;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      last_grant_q     <= 1'b1;
      id_q             <= 1'b0;
      we_q             <= 1'b0;
      illegal_q        <= 1'b0;
      ack_q            <= '0;
      err_q            <= '0;
      rdata_q          <= '0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      busy_q           <= 1'b0;
      grant_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      id_q             <= id_d;
      we_q             <= we_d;
      illegal_q        <= illegal_d;
      ack_q            <= ack_d;
      err_q            <= err_d;
      rdata_q          <= rdata_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      busy_q           <= busy_d;
      grant_q          <= grant_d;
    end
  end

endmodule
